// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port block-memory arbiter: sequencer states,
// requester port ids and the round-robin winner rule.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RELEASE = 2'd1,
        ISSUE   = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    localparam logic PORT_IC = 1'b0;
    localparam logic PORT_DC = 1'b1;

    // With both ports requesting, the one not served last wins.
    function automatic logic rr_winner(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1] ? PORT_DC : PORT_IC;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-request round-robin picker.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = rr_winner(req, last);
    end

endmodule

// File: rtl/mem_block_arbiter.sv
// Two-port round-robin arbiter and sequencer for the address-change-triggered
// delayed_memory block store; one latched whole-block access per grant.
module mem_block_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 10,
    parameter int BLOCK_OFFSET_WIDTH = 3
) (
    input  logic                                             clk,
    input  logic                                             rstn,
    input  logic                                             p0_req,
    input  logic                                             p0_we,
    input  logic [ADDR_WIDTH-1:0]                            p0_addr,
    input  logic [(DATA_WIDTH << BLOCK_OFFSET_WIDTH)-1:0]    p0_wdata,
    output logic                                             p0_done,
    output logic [(DATA_WIDTH << BLOCK_OFFSET_WIDTH)-1:0]    p0_rdata,
    input  logic                                             p1_req,
    input  logic                                             p1_we,
    input  logic [ADDR_WIDTH-1:0]                            p1_addr,
    input  logic [(DATA_WIDTH << BLOCK_OFFSET_WIDTH)-1:0]    p1_wdata,
    output logic                                             p1_done,
    output logic [(DATA_WIDTH << BLOCK_OFFSET_WIDTH)-1:0]    p1_rdata,
    output logic [ADDR_WIDTH-1:0]                            mem_addr,
    output logic                                             mem_we,
    output logic [(DATA_WIDTH << BLOCK_OFFSET_WIDTH)-1:0]    mem_block_din,
    input  logic                                             mem_valid,
    input  logic [(DATA_WIDTH << BLOCK_OFFSET_WIDTH)-1:0]    mem_block_dout,
    output logic                                             busy,
    output logic                                             grant_id
);

    localparam int BLOCK_SIZE  = 1 << BLOCK_OFFSET_WIDTH;
    localparam int BLOCK_WIDTH = BLOCK_SIZE * DATA_WIDTH;

    arb_state_t              state;
    arb_state_t              state_nxt;
    logic                    armed;
    logic                    last_grant;
    logic                    gnt_valid;
    logic                    gnt_id;
    logic                    grant;
    logic                    capture;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic                    win_we;
    logic [BLOCK_WIDTH-1:0]  win_wdata;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic                    lat_we;
    logic [BLOCK_WIDTH-1:0]  lat_wdata;

    rr_pick2 u_pick (
        .req       ({p1_req, p0_req}),
        .last      (last_grant),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        if (gnt_id == PORT_DC) begin
            win_addr  = p1_addr;
            win_we    = p1_we;
            win_wdata = p1_wdata;
        end else begin
            win_addr  = p0_addr;
            win_we    = p0_we;
            win_wdata = p0_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        capture   = 1'b0;
        busy      = (state != IDLE);
        p0_done   = 1'b0;
        p1_done   = 1'b0;
        unique case (state)
            IDLE: begin
                // Only grant while memory sits in VALID, i.e. is quiescent.
                if (gnt_valid && mem_valid) begin
                    grant     = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                state_nxt = ISSUE;
            end
            ISSUE: begin
                // A valid seen before the memory dropped it belongs to the previous access.
                if (armed && mem_valid) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                p0_done   = (grant_id == PORT_IC);
                p1_done   = (grant_id == PORT_DC);
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            armed         <= 1'b0;
            last_grant    <= PORT_DC;
            grant_id      <= PORT_IC;
            lat_addr      <= '0;
            lat_we        <= 1'b0;
            lat_wdata     <= '0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_block_din <= '0;
        end else begin
            if (grant) begin
                lat_addr   <= win_addr;
                lat_we     <= win_we;
                lat_wdata  <= win_wdata;
                last_grant <= gnt_id;
                grant_id   <= gnt_id;
                // Complemented address forces an address change even for a repeat block.
                mem_addr   <= ~win_addr;
                mem_we     <= 1'b0;
            end
            case (state)
                RELEASE: begin
                    mem_addr      <= lat_addr;
                    mem_we        <= lat_we;
                    mem_block_din <= lat_wdata;
                    armed         <= 1'b0;
                end
                ISSUE: begin
                    if (!mem_valid) begin
                        armed <= 1'b1;
                    end
                end
                DONE: begin
                    mem_we <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // NOTE: the returned-block registers are ordinary flops, not a RAM, so they
    // take the asynchronous reset like every other register here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else if (capture) begin
            if (grant_id == PORT_DC) begin
                p1_rdata <= mem_block_dout;
            end else begin
                p0_rdata <= mem_block_dout;
            end
        end
    end

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Self-checking bench for mem_block_arbiter with a behavioural delayed_memory
// and an array scoreboard of the expected memory contents.
module tb_mem_block_arbiter;

    localparam int DW         = 32;
    localparam int AW         = 10;
    localparam int BOW        = 3;
    localparam int BS         = 1 << BOW;
    localparam int BW         = BS * DW;
    localparam int MEM_LAT    = 16 + BS;
    localparam int LAT_MAX    = 32 + BS;
    localparam int TXN_BUDGET = 300;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          p0_req = 1'b0, p1_req = 1'b0;
    logic          p0_we = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [BW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic          p0_done, p1_done;
    logic [BW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [BW-1:0] mem_block_din;
    logic          mem_valid = 1'b0;
    logic [BW-1:0] mem_block_dout = '0;
    logic          busy;
    logic          grant_id;

    int checks = 0;
    int errors = 0;

    mem_block_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_OFFSET_WIDTH(BOW)) dut (
        .clk(clk), .rstn(rstn),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_done(p1_done), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_block_din(mem_block_din),
        .mem_valid(mem_valid), .mem_block_dout(mem_block_dout),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Behavioural delayed_memory: any address change restarts an access of
    // MEM_LAT cycles with valid low; the access uses the address/we/din at completion.
    logic [DW-1:0] mem_store [1024];
    logic [DW-1:0] ref_mem   [1024];
    logic [AW-1:0] mdl_prev_addr = '0;
    int            mdl_cnt = MEM_LAT;

    always @(posedge clk) begin
        int base;
        if (mem_addr !== mdl_prev_addr) begin
            mdl_prev_addr <= mem_addr;
            mem_valid     <= 1'b0;
            mdl_cnt       <= MEM_LAT;
        end else if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) begin
                mem_valid <= 1'b1;
                base = int'(mem_addr) & ~(BS - 1);
                if (mem_we) begin
                    for (int i = 0; i < BS; i++) mem_store[base + i] <= mem_block_din[i*DW +: DW];
                    mem_block_dout <= mem_block_din;
                end else begin
                    for (int i = 0; i < BS; i++) mem_block_dout[i*DW +: DW] <= mem_store[base + i];
                end
            end
        end
    end

    // Observation of grants (busy rising edges) and done pulses.
    bit   busy_prev = 1'b0, valid_seen = 1'b0, early_grant = 1'b0, both_done = 1'b0;
    int   p0_done_cnt = 0, p1_done_cnt = 0;
    logic grant_q [$];

    always @(negedge clk) begin
        if (busy && !busy_prev) begin
            grant_q.push_back(grant_id);
            if (!valid_seen) early_grant = 1'b1;
        end
        busy_prev = busy;
        if (mem_valid) valid_seen = 1'b1;
        if (p0_done && p1_done) both_done = 1'b1;
        if (p0_done) p0_done_cnt++;
        if (p1_done) p1_done_cnt++;
    end

    function automatic logic [DW-1:0] init_word(input int a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    function automatic logic [BW-1:0] fill_block(input logic [DW-1:0] w0, input logic [DW-1:0] step);
        logic [BW-1:0] b;
        for (int i = 0; i < BS; i++) b[i*DW +: DW] = w0 + step * 32'(i);
        return b;
    endfunction

    function automatic logic [BW-1:0] rand_block();
        logic [BW-1:0] b;
        for (int i = 0; i < BS; i++) b[i*DW +: DW] = $urandom();
        return b;
    endfunction

    function automatic logic [BW-1:0] ref_block(input logic [AW-1:0] addr);
        logic [BW-1:0] b;
        int base;
        base = int'(addr) & ~(BS - 1);
        for (int i = 0; i < BS; i++) b[i*DW +: DW] = ref_mem[base + i];
        return b;
    endfunction

    function automatic void ref_write(input logic [AW-1:0] addr, input logic [BW-1:0] data);
        int base;
        base = int'(addr) & ~(BS - 1);
        for (int i = 0; i < BS; i++) ref_mem[base + i] = data[i*DW +: DW];
    endfunction

    // One requester transaction; the expected block is taken from the scoreboard at completion.
    task automatic do_txn(input int port, input logic we, input logic [AW-1:0] addr,
                          input logic [BW-1:0] wdata, output logic [BW-1:0] rdata,
                          output logic [BW-1:0] exp, output int cycles, output bit timed_out);
        @(negedge clk);
        if (port == 0) begin
            p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
        end
        timed_out = 1'b1;
        cycles    = 0;
        rdata     = '0;
        exp       = '0;
        for (int c = 0; c < TXN_BUDGET; c++) begin
            @(negedge clk);
            cycles++;
            if ((port == 0) ? p0_done : p1_done) begin
                timed_out = 1'b0;
                rdata     = (port == 0) ? p0_rdata : p1_rdata;
                if (we) ref_write(addr, wdata);
                exp = ref_block(addr);
                break;
            end
        end
        if (port == 0) p0_req = 1'b0;
        else           p1_req = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
        checks++; if (mem_block_din !== '0) begin errors++; $display("FAIL reset_mem_din got %h exp 0", mem_block_din); end
        checks++; if ({p0_done, p1_done} !== 2'b00) begin errors++; $display("FAIL reset_done got %b exp 00", {p0_done, p1_done}); end
        checks++; if (p0_rdata !== '0 || p1_rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0", p0_rdata[31:0], p1_rdata[31:0]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant_id got %b exp 0", grant_id); end
    endtask

    task automatic test_startup();
        logic [BW-1:0] rd, exp;
        bit got;
        p0_we = 1'b0; p0_addr = 10'h010; p0_req = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        got = 1'b0;
        rd  = '0;
        for (int c = 0; c < TXN_BUDGET; c++) begin
            @(negedge clk);
            if (p0_done) begin got = 1'b1; rd = p0_rdata; p0_req = 1'b0; break; end
        end
        p0_req = 1'b0;
        exp = fill_block(32'hC0DE_0010, 32'd1);
        checks++; if (!got) begin errors++; $display("FAIL startup_done got none exp one pulse"); end
        checks++; if (early_grant) begin errors++; $display("FAIL startup_early_grant got grant before mem_valid exp none"); end
        checks++; if (rd !== exp) begin errors++; $display("FAIL startup_rdata got %h exp %h", rd, exp); end
        repeat (10) @(negedge clk);
        checks++; if (p0_done_cnt != 1) begin errors++; $display("FAIL startup_done_count got %0d exp 1", p0_done_cnt); end
    endtask

    task automatic test_write_read();
        logic [BW-1:0] rd, ex, wd;
        int cyc;
        bit to;
        wd = fill_block(32'hA0, 32'd1);
        do_txn(1, 1'b1, 10'h048, wd, rd, ex, cyc, to);
        checks++; if (to || cyc > LAT_MAX) begin errors++; $display("FAIL wr_latency got %0d timeout %b exp <= %0d", cyc, to, LAT_MAX); end
        do_txn(0, 1'b0, 10'h048, '0, rd, ex, cyc, to);
        checks++; if (to || cyc > LAT_MAX) begin errors++; $display("FAIL rd_latency got %0d timeout %b exp <= %0d", cyc, to, LAT_MAX); end
        checks++; if (rd !== wd) begin errors++; $display("FAIL write_read_data got %h exp %h", rd, wd); end
    endtask

    task automatic test_arbitration();
        logic [BW-1:0] r0a, e0a, r0b, e0b, r1a, e1a, r1b, e1b, rx, ex;
        int c0a, c0b, c1a, c1b, cx;
        bit t0a, t0b, t1a, t1b, tx;
        // Leave port 1 as the last one served so port 0 wins the first tie.
        do_txn(1, 1'b0, 10'h100, '0, rx, ex, cx, tx);
        grant_q.delete();
        both_done = 1'b0;
        fork
            begin
                do_txn(0, 1'b0, 10'h030, '0, r0a, e0a, c0a, t0a);
                do_txn(0, 1'b0, 10'h038, '0, r0b, e0b, c0b, t0b);
            end
            begin
                do_txn(1, 1'b0, 10'h200, '0, r1a, e1a, c1a, t1a);
                do_txn(1, 1'b0, 10'h208, '0, r1b, e1b, c1b, t1b);
            end
        join
        checks++; if (t0a || t0b || t1a || t1b) begin errors++; $display("FAIL arb_complete got timeouts %b%b%b%b exp 0000", t0a, t0b, t1a, t1b); end
        checks++; if (grant_q.size() != 4) begin errors++; $display("FAIL arb_grant_count got %0d exp 4", grant_q.size()); end
        for (int i = 0; i < grant_q.size() && i < 4; i++) begin
            checks++;
            if (grant_q[i] !== (i % 2 == 1)) begin
                errors++; $display("FAIL arb_order grant %0d got port %b exp port %0d", i, grant_q[i], i % 2);
            end
        end
        checks++; if (both_done) begin errors++; $display("FAIL arb_double_done got simultaneous dones exp none"); end
        checks++; if (r0a !== e0a || r0b !== e0b) begin errors++; $display("FAIL arb_p0_data got %h/%h exp %h/%h", r0a[31:0], r0b[31:0], e0a[31:0], e0b[31:0]); end
        checks++; if (r1a !== e1a || r1b !== e1b) begin errors++; $display("FAIL arb_p1_data got %h/%h exp %h/%h", r1a[31:0], r1b[31:0], e1a[31:0], e1b[31:0]); end
    endtask

    task automatic test_same_block();
        logic [BW-1:0] rd, ex, w22;
        int cyc;
        bit to1, to2, to3;
        w22 = fill_block(32'h22, 32'd0);
        do_txn(1, 1'b1, 10'h020, fill_block(32'h11, 32'd0), rd, ex, cyc, to1);
        do_txn(1, 1'b1, 10'h020, w22, rd, ex, cyc, to2);
        do_txn(0, 1'b0, 10'h020, '0, rd, ex, cyc, to3);
        checks++; if (to1 || to2 || to3) begin errors++; $display("FAIL same_block_complete got timeouts %b%b%b exp 000", to1, to2, to3); end
        checks++; if (rd !== w22) begin errors++; $display("FAIL same_block_data got %h exp %h", rd, w22); end
        do_txn(0, 1'b0, 10'h3DF, '0, rd, ex, cyc, to1);
        checks++; if (to1) begin errors++; $display("FAIL complement_addr_complete got timeout exp done"); end
        checks++; if (rd !== fill_block(init_word(32'h3D8), 32'd1)) begin errors++; $display("FAIL complement_addr_data got %h exp init block 0x3D8", rd); end
    endtask

    task automatic test_latch_integrity();
        logic [AW-1:0] a;
        logic [BW-1:0] wd, rd, ex;
        int bc, cyc;
        bit got, to;
        a  = AW'($urandom_range(0, 1023));
        wd = rand_block();
        @(negedge clk);
        p0_we = 1'b1; p0_addr = a; p0_wdata = wd; p0_req = 1'b1;
        bc  = 0;
        got = 1'b0;
        for (int c = 0; c < TXN_BUDGET; c++) begin
            @(negedge clk);
            if (busy) bc++;
            if (bc >= 2) begin
                checks++;
                if (mem_addr !== a || mem_we !== 1'b1 || mem_block_din !== wd) begin
                    errors++;
                    $display("FAIL latch_hold busy cycle %0d got addr %h we %b din0 %h exp addr %h we 1 din0 %h",
                             bc, mem_addr, mem_we, mem_block_din[31:0], a, wd[31:0]);
                end
            end
            if (p0_done) begin got = 1'b1; break; end
            if (busy) begin
                p0_addr  = AW'($urandom());
                p0_wdata = rand_block();
            end
        end
        p0_req = 1'b0;
        checks++; if (!got) begin errors++; $display("FAIL latch_done got timeout exp done"); end
        ref_write(a, wd);
        do_txn(0, 1'b0, a, '0, rd, ex, cyc, to);
        checks++; if (to || rd !== wd) begin errors++; $display("FAIL latch_readback got %h timeout %b exp %h", rd[31:0], to, wd[31:0]); end
    endtask

    task automatic test_reset_mid_issue();
        logic [AW-1:0] a;
        logic [BW-1:0] rd, ex;
        int bc, d0, d1, cyc;
        bit to;
        a = AW'($urandom_range(0, 1023));
        @(negedge clk);
        p0_we = 1'b0; p0_addr = a; p0_req = 1'b1;
        bc = 0;
        for (int c = 0; c < TXN_BUDGET && bc < 4; c++) begin
            @(negedge clk);
            if (busy) bc++;
        end
        checks++; if (bc < 4) begin errors++; $display("FAIL rst_mid_reach_issue got %0d busy cycles exp 4", bc); end
        d0 = p0_done_cnt;
        d1 = p1_done_cnt;
        rstn = 1'b0;
        #1;
        checks++; if (mem_addr !== '0 || mem_we !== 1'b0 || mem_block_din !== '0) begin
            errors++; $display("FAIL rst_mid_mem got addr %h we %b din0 %h exp 0", mem_addr, mem_we, mem_block_din[31:0]);
        end
        checks++; if (p0_rdata !== '0 || p1_rdata !== '0) begin
            errors++; $display("FAIL rst_mid_rdata got %h/%h exp 0", p0_rdata[31:0], p1_rdata[31:0]);
        end
        checks++; if ({busy, grant_id, p0_done, p1_done} !== 4'b0000) begin
            errors++; $display("FAIL rst_mid_ctrl got busy/gid/done %b exp 0000", {busy, grant_id, p0_done, p1_done});
        end
        p0_req = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (50) @(negedge clk);
        checks++; if (p0_done_cnt != d0 || p1_done_cnt != d1) begin
            errors++; $display("FAIL rst_mid_no_done got %0d/%0d exp %0d/%0d", p0_done_cnt, p1_done_cnt, d0, d1);
        end
        do_txn(0, 1'b0, a, '0, rd, ex, cyc, to);
        checks++; if (to || rd !== ex) begin errors++; $display("FAIL rst_mid_recover got %h timeout %b exp %h", rd[31:0], to, ex[31:0]); end
    endtask

    task automatic test_random();
        logic [AW-1:0] a0, a1;
        logic [BW-1:0] d0, d1, r0, r1, e0, e1;
        logic          w0, w1;
        int            mode, c0, c1;
        bit            t0, t1;
        for (int it = 0; it < 12; it++) begin
            mode = $urandom_range(0, 2);
            w0 = 1'($urandom_range(0, 1)); a0 = AW'($urandom_range(0, 127)); d0 = rand_block();
            w1 = 1'($urandom_range(0, 1)); a1 = AW'($urandom_range(0, 127)); d1 = rand_block();
            t0 = 1'b0; t1 = 1'b0; c0 = 0; c1 = 0;
            if (mode == 0) begin
                do_txn(0, w0, a0, d0, r0, e0, c0, t0);
            end else if (mode == 1) begin
                do_txn(1, w1, a1, d1, r1, e1, c1, t1);
            end else begin
                fork
                    do_txn(0, w0, a0, d0, r0, e0, c0, t0);
                    do_txn(1, w1, a1, d1, r1, e1, c1, t1);
                join
            end
            if (mode != 1) begin
                checks++;
                if (t0 || (!w0 && r0 !== e0) || (mode == 0 && c0 > LAT_MAX)) begin
                    errors++; $display("FAIL rand_p0 it %0d we %b addr %h got %h lat %0d timeout %b exp %h", it, w0, a0, r0[31:0], c0, t0, e0[31:0]);
                end
            end
            if (mode != 0) begin
                checks++;
                if (t1 || (!w1 && r1 !== e1) || (mode == 1 && c1 > LAT_MAX)) begin
                    errors++; $display("FAIL rand_p1 it %0d we %b addr %h got %h lat %0d timeout %b exp %h", it, w1, a1, r1[31:0], c1, t1, e1[31:0]);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_store[i] = init_word(i);
            ref_mem[i]   = init_word(i);
        end
        #1 rstn = 1'b0;
        test_reset();
        test_startup();
        test_write_read();
        test_arbitration();
        test_same_block();
        test_latch_integrity();
        test_reset_mid_issue();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_block_arbiter.md
# mem_block_arbiter

Two-requester arbiter and sequencer in front of the `delayed_memory` block store. It lets the instruction-cache refill port (port 0) and the data-cache refill/writeback port (port 1) share one memory. It latches one whole-block read or write per grant and drives the memory's address-change-triggered protocol, including a forced address change so that consecutive accesses to the same block are re-executed. It returns a one-cycle done pulse with the block data. Grants alternate round-robin.

## Interface
- DATA_WIDTH, 32, bits per word
- ADDR_WIDTH, 10, word address width
- BLOCK_OFFSET_WIDTH, 3, log2 words per block; BLOCK_SIZE = 1<<BLOCK_OFFSET_WIDTH (local)
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- p0_req / p1_req  in  1  request; held high until the matching done
- p0_we / p1_we  in  1  1 = block write, 0 = block read
- p0_addr / p1_addr  in  ADDR_WIDTH  word address; offset bits are ignored by memory
- p0_wdata / p1_wdata  in  BLOCK_SIZE*DATA_WIDTH  write block; word 0 in the LSBs
- p0_done / p1_done  out  1  one-cycle completion pulse
- p0_rdata / p1_rdata  out  BLOCK_SIZE*DATA_WIDTH  block captured at completion; holds until the next completion on that port
- mem_addr  out  ADDR_WIDTH  to memory addr
- mem_we  out  1  to memory we
- mem_block_din  out  BLOCK_SIZE*DATA_WIDTH  to memory block_din
- mem_valid  in  1  from memory valid
- mem_block_dout  in  BLOCK_SIZE*DATA_WIDTH  from memory block_dout
- busy  out  1  high in any state other than IDLE
- grant_id  out  1  port currently or last granted

## Operation
- **States:** IDLE, RELEASE, ISSUE, DONE.
- **IDLE:**
  - Grant only when (p0_req | p1_req) and mem_valid==1, so memory is known to be quiescent in VALID.
  - Latch addr, we and wdata of the winner into internal registers.
  - Go to RELEASE.
- **Round-robin:**
  - last_grant register, reset value 1.
  - A single request wins.
  - With both requests, the port != last_grant wins; last_grant is updated at grant.
- **RELEASE (exactly 1 cycle):**
  - mem_addr = ~lat_addr (bitwise), mem_we = 0.
  - This guarantees that the ISSUE address differs from the value driven in the previous cycle.
- **ISSUE:**
  - mem_addr = lat_addr, mem_we = lat_we, mem_block_din = lat_wdata, all held constant.
  - The armed flag is cleared on entry and set on the first cycle with mem_valid==0.
  - When armed and mem_valid==1: capture mem_block_dout into the granted port's rdata and go to DONE.
  - mem_valid is ignored until armed, because a stale valid persists up to 2 cycles into ISSUE.
- **DONE (1 cycle):**
  - Granted port's done = 1; then go to IDLE.
  - The requester drops req at the edge that ends DONE, so it is low in the following IDLE cycle.
- **IDLE outputs:** mem_addr, mem_we (forced 0) and mem_block_din hold their last values, so memory stays in VALID.
- **Reads:** rdata is meaningful. For writes, rdata is still updated, but its contents are unspecified.
- **Requester input changes:** changes to a requester's addr/we/wdata after grant have no effect.

## Timing
- **Reset values:**
  - State IDLE, armed 0, last_grant 1.
  - mem_addr 0, mem_we 0, mem_block_din 0.
  - Both done 0, both rdata 0, busy 0, grant_id 0.
- **Memory after reset:** memory sees a stable address 0 and performs a read of block 0. The first grant therefore cannot occur before that read raises mem_valid (at least 16+BLOCK_SIZE cycles).
- **Request latency:** request to done = 1 (grant) + 1 (RELEASE) + memory latency (about 16 + BLOCK_SIZE + 3) + 1 (DONE). Requirement: at most 32 + BLOCK_SIZE cycles once mem_valid is high.
- **Back-to-back grants:** a new grant is possible in the cycle after DONE.
- **Reset mid-transaction:** everything returns to reset values asynchronously and no done is issued. A write interrupted this way leaves the block partially written; this is not guarded.
- **Busy:** asserted from the cycle after grant through DONE inclusive.

## Structure
- **Shared package `mem_arb_pkg`:**
  - State enum {IDLE, RELEASE, ISSUE, DONE}.
  - Port id constants PORT_IC = 0, PORT_DC = 1.
- **Sub-module `rr_pick2`:**
  - Combinational two-request round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: gnt_valid, gnt_id.
  - Instantiated once.
- **Memory:** `delayed_memory` is instantiated outside this block, at the cache top level.

## Test plan
- **Reset/startup:**
  - Hold p0_req read of 0x010 from reset.
  - Required: no grant before mem_valid first rises; p0_done exactly once; p0_rdata = init-file words 0x010–0x017.
- **Write then read:**
  - p1 writes 0x048 with words 0xA0..0xA7 (word i = 0xA0+i); then p0 reads 0x048.
  - Required: p0_rdata word i = 0xA0+i.
- **Arbitration:**
  - Both requests asserted together, each re-asserted after its done.
  - Required: grant order p0, p1, p0, p1; grant_id matches; never two dones in the same cycle.
- **Same-block repeat:**
  - p1 writes 0x020 with 0x11, then writes 0x020 with 0x22, then p0 reads 0x020.
  - Required: read returns 0x22 in every word.
  - Repeat with next address = ~previous (0x3DF after 0x020); both must complete.
- **Latch integrity:**
  - Change p0_addr and p0_wdata every cycle during ISSUE.
  - Required: mem_addr, mem_we and mem_block_din stay constant until DONE.
- **Reset mid-ISSUE:**
  - Pulse rstn low for 1 cycle during ISSUE.
  - Required: all outputs at reset values immediately; no done pulse; the next request completes normally.
